// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Requester-side controller for the unified program/data memory. Arbitrates
//   between instruction fetches and data loads/stores (data wins), drives the
//   memory strobes from the current state, and returns one response per access.
//
// Ports
//   CLK, RESET                 : clock, synchronous active-high reset
//   i_fetch_req, i_pc          : fetch request (held until granted) and address
//   o_fetch_gnt                : fetch accepted this cycle
//   o_instr, o_instr_valid     : fetched instruction and its one-cycle pulse
//   i_dreq, i_dwe, i_daddr,
//   i_dwdata                   : data request (held until granted), 1=store, address, store data
//   o_dgnt                     : data request accepted this cycle
//   o_drdata, o_dvalid,
//   o_dfault                   : load data, response pulse, fault qualifier
//   o_fault_cnt                : saturating count of faulted data accesses
//   o_busy                     : controller not idle
//   o_mem_cs/we/sel            : memory chip select, write enable, instr(0)/data(1) select
//   o_mem_pc, o_mem_addr,
//   o_mem_wdata                : latched fetch address, data address, store data
//   i_mem_rdata, i_mem_error   : registered memory read data and error flag
module mem_access_ctrl #(
  parameter int ADDR_BITS        = 9,
  parameter int DATA_BITS        = 16,
  parameter int INSTRUCTION_SIZE = 16,
  parameter int ROM_SIZE         = 64,
  parameter int MEM_SIZE         = 256
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        i_fetch_req,
  input  logic [ADDR_BITS-1:0]        i_pc,
  output logic                        o_fetch_gnt,
  output logic [INSTRUCTION_SIZE-1:0] o_instr,
  output logic                        o_instr_valid,
  input  logic                        i_dreq,
  input  logic                        i_dwe,
  input  logic [ADDR_BITS-1:0]        i_daddr,
  input  logic [DATA_BITS-1:0]        i_dwdata,
  output logic                        o_dgnt,
  output logic [INSTRUCTION_SIZE-1:0] o_drdata,
  output logic                        o_dvalid,
  output logic                        o_dfault,
  output logic [7:0]                  o_fault_cnt,
  output logic                        o_busy,
  output logic                        o_mem_cs,
  output logic                        o_mem_we,
  output logic                        o_mem_sel,
  output logic [ADDR_BITS-1:0]        o_mem_pc,
  output logic [ADDR_BITS-1:0]        o_mem_addr,
  output logic [DATA_BITS-1:0]        o_mem_wdata,
  input  logic [INSTRUCTION_SIZE-1:0] i_mem_rdata,
  input  logic                        i_mem_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DREAD  = 3'd2;
  localparam logic [2:0] S_DWRITE = 3'd3;
  localparam logic [2:0] S_RESP_F = 3'd4;
  localparam logic [2:0] S_RESP_D = 3'd5;

  // One extra bit so MEM_SIZE itself is representable when it equals 2**ADDR_BITS.
  localparam logic [ADDR_BITS:0] MEM_LIMIT = (ADDR_BITS+1)'(MEM_SIZE);

  // The writable region must start inside the memory; ROM protection itself is
  // enforced by the memory and reported through i_mem_error.
  if (ROM_SIZE > MEM_SIZE) begin : g_rom_larger_than_mem
  end

  logic [2:0]                  state_q, state_d;
  logic [ADDR_BITS-1:0]        pc_q, addr_q;
  logic [DATA_BITS-1:0]        wdata_q;
  logic                        we_q, oor_q, hold_q;
  logic [INSTRUCTION_SIZE-1:0] instr_q, drdata_q;
  logic                        instr_vld_q, dvalid_q, dfault_q;
  logic [7:0]                  fault_cnt_q;

  logic idle, dgnt, fgnt, daddr_oor, resp_d_done, access_fault;

  assign idle         = (state_q == S_IDLE);
  assign dgnt         = idle & i_dreq;
  assign fgnt         = idle & i_fetch_req & ~i_dreq;
  assign daddr_oor    = ({1'b0, i_daddr} >= MEM_LIMIT);
  // An out-of-range access parks in RESP_D for one extra cycle (hold_q) so
  // its response arrives with the same latency as a real memory cycle.
  assign resp_d_done  = (state_q == S_RESP_D) & ~hold_q;
  assign access_fault = (we_q & i_mem_error) | oor_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dgnt) begin
          if (daddr_oor)  state_d = S_RESP_D;
          else if (i_dwe) state_d = S_DWRITE;
          else            state_d = S_DREAD;
        end else if (fgnt) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_RESP_F;
      S_DREAD:  state_d = S_RESP_D;
      S_DWRITE: state_d = S_RESP_D;
      S_RESP_F: state_d = S_IDLE;
      S_RESP_D: state_d = hold_q ? S_RESP_D : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      hold_q      <= 1'b0;
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
      drdata_q    <= '0;
      dvalid_q    <= 1'b0;
      dfault_q    <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_vld_q <= 1'b0;
      dvalid_q    <= 1'b0;
      dfault_q    <= 1'b0;

      if (dgnt) begin
        addr_q  <= i_daddr;
        wdata_q <= i_dwdata;
        we_q    <= i_dwe;
        oor_q   <= daddr_oor;
        hold_q  <= daddr_oor;
      end
      if (fgnt) begin
        pc_q <= i_pc;
      end

      if (state_q == S_RESP_D) begin
        hold_q <= 1'b0;
      end

      if (resp_d_done) begin
        dvalid_q <= 1'b1;
        dfault_q <= access_fault;
        if (!we_q) begin
          drdata_q <= i_mem_rdata;
        end
        if (access_fault && (fault_cnt_q != 8'hFF)) begin
          fault_cnt_q <= fault_cnt_q + 8'd1;
        end
      end

      if (state_q == S_RESP_F) begin
        instr_q     <= i_mem_rdata;
        instr_vld_q <= 1'b1;
      end
    end
  end

  // Memory strobes are a pure decode of the state.
  assign o_mem_cs  = (state_q == S_FETCH) | (state_q == S_DREAD) | (state_q == S_DWRITE);
  assign o_mem_we  = (state_q == S_DWRITE);
  assign o_mem_sel = (state_q == S_DREAD) | (state_q == S_DWRITE);

  assign o_fetch_gnt   = fgnt;
  assign o_dgnt        = dgnt;
  assign o_instr       = instr_q;
  assign o_instr_valid = instr_vld_q;
  assign o_drdata      = drdata_q;
  assign o_dvalid      = dvalid_q;
  assign o_dfault      = dfault_q;
  assign o_fault_cnt   = fault_cnt_q;
  assign o_busy        = ~idle;
  assign o_mem_pc      = pc_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a small memory model answers the DUT's
// strobes, and a transaction-level reference predicts every output each cycle.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        i_fetch_req;
  logic [8:0]  i_pc;
  logic        o_fetch_gnt;
  logic [15:0] o_instr;
  logic        o_instr_valid;
  logic        i_dreq;
  logic        i_dwe;
  logic [8:0]  i_daddr;
  logic [15:0] i_dwdata;
  logic        o_dgnt;
  logic [15:0] o_drdata;
  logic        o_dvalid;
  logic        o_dfault;
  logic [7:0]  o_fault_cnt;
  logic        o_busy;
  logic        o_mem_cs, o_mem_we, o_mem_sel;
  logic [8:0]  o_mem_pc, o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_err;

  mem_access_ctrl #(
    .ADDR_BITS(9), .DATA_BITS(16), .INSTRUCTION_SIZE(16), .ROM_SIZE(64), .MEM_SIZE(256)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .i_fetch_req(i_fetch_req), .i_pc(i_pc), .o_fetch_gnt(o_fetch_gnt),
    .o_instr(o_instr), .o_instr_valid(o_instr_valid),
    .i_dreq(i_dreq), .i_dwe(i_dwe), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
    .o_dgnt(o_dgnt), .o_drdata(o_drdata), .o_dvalid(o_dvalid), .o_dfault(o_dfault),
    .o_fault_cnt(o_fault_cnt), .o_busy(o_busy),
    .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we), .o_mem_sel(o_mem_sel),
    .o_mem_pc(o_mem_pc), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_error(mem_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cs_cnt, we_cnt, dv_cnt;

  // memory environment contents and the reference model's own copy
  logic [15:0] env_mem [0:511];
  logic [15:0] ref_mem [0:511];

  // reference model state: transaction in flight and expected outputs
  int          m_busy;
  logic        m_dg, m_fg;
  logic        t_data, t_we, t_oor;
  logic [8:0]  t_addr, t_pc;
  logic [15:0] t_wdata;
  logic [15:0] last_read;
  logic [15:0] e_instr, e_drdata, e_wdata;
  logic        e_ivld, e_dvalid, e_dfault;
  logic [7:0]  e_cnt;
  logic [8:0]  e_pc, e_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous memory: registered read data, ERROR on a write into ROM.
  // Read cycles present a random ERROR that loads must ignore.
  task automatic env_step();
    if (RESET) begin
      mem_rdata <= 16'h0;
      mem_err   <= 1'b0;
    end else if (o_mem_cs) begin
      if (o_mem_we) begin
        if (o_mem_addr < 9'd64) begin
          mem_err <= 1'b1;
        end else begin
          env_mem[o_mem_addr] = o_mem_wdata;
          mem_err <= 1'b0;
        end
      end else begin
        mem_rdata <= env_mem[o_mem_sel ? o_mem_addr : o_mem_pc];
        mem_err   <= 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Every access takes two edges after its grant: the memory acts on the
  // first, the response is delivered on the second.
  task automatic model_step();
    logic f;
    m_dg = 1'b0;
    m_fg = 1'b0;
    if (RESET) begin
      m_busy = 0; last_read = 16'h0;
      e_instr = 16'h0; e_drdata = 16'h0; e_wdata = 16'h0;
      e_ivld = 1'b0; e_dvalid = 1'b0; e_dfault = 1'b0;
      e_cnt = 8'h0; e_pc = 9'h0; e_addr = 9'h0;
    end else begin
      e_ivld = 1'b0; e_dvalid = 1'b0; e_dfault = 1'b0;
      if (m_busy == 2) begin
        if (!t_data) last_read = ref_mem[t_pc];
        else if (!t_oor) begin
          if (!t_we) last_read = ref_mem[t_addr];
          else if (t_addr >= 9'd64) ref_mem[t_addr] = t_wdata;
        end
      end else if (m_busy == 1) begin
        if (!t_data) begin
          e_instr = last_read;
          e_ivld  = 1'b1;
        end else begin
          f = t_oor || (t_we && (t_addr < 9'd64));
          e_dvalid = 1'b1;
          e_dfault = f;
          if (!t_we) e_drdata = last_read;
          if (f && (e_cnt != 8'd255)) e_cnt = e_cnt + 8'd1;
        end
      end
      if (m_busy != 0) begin
        m_busy--;
      end else if (i_dreq) begin
        m_dg = 1'b1; m_busy = 2;
        t_data = 1'b1; t_we = i_dwe; t_addr = i_daddr; t_wdata = i_dwdata;
        t_oor = (i_daddr >= 9'd256);
        e_addr = i_daddr; e_wdata = i_dwdata;
      end else if (i_fetch_req) begin
        m_fg = 1'b1; m_busy = 2;
        t_data = 1'b0; t_pc = i_pc; t_oor = 1'b0;
        e_pc = i_pc;
      end
    end
  endtask

  task automatic check_regs();
    logic acc;
    acc = (m_busy == 2) && !(t_data && t_oor);
    chk("instr",     32'(o_instr),       32'(e_instr));
    chk("ivalid",    32'(o_instr_valid), 32'(e_ivld));
    chk("drdata",    32'(o_drdata),      32'(e_drdata));
    chk("dvalid",    32'(o_dvalid),      32'(e_dvalid));
    chk("dfault",    32'(o_dfault),      32'(e_dfault));
    chk("fault_cnt", 32'(o_fault_cnt),   32'(e_cnt));
    chk("busy",      32'(o_busy),        32'(m_busy != 0));
    chk("mem_cs",    32'(o_mem_cs),      32'(acc));
    chk("mem_we",    32'(o_mem_we),      32'(acc && t_data && t_we));
    chk("mem_sel",   32'(o_mem_sel),     32'(acc && t_data));
    chk("mem_pc",    32'(o_mem_pc),      32'(e_pc));
    chk("mem_addr",  32'(o_mem_addr),    32'(e_addr));
    chk("mem_wdata", 32'(o_mem_wdata),   32'(e_wdata));
  endtask

  // Called at a falling edge with this cycle's inputs already applied.
  task automatic tick();
    #1;
    chk("dgnt", 32'(o_dgnt),      32'((m_busy == 0) && i_dreq));
    chk("fgnt", 32'(o_fetch_gnt), 32'((m_busy == 0) && i_fetch_req && !i_dreq));
    @(posedge CLK);
    env_step();
    model_step();
    @(negedge CLK);
    check_regs();
    if (o_mem_cs) cs_cnt++;
    if (o_mem_we) we_cnt++;
    if (o_dvalid) dv_cnt++;
    if (m_dg) i_dreq = 1'b0;
    if (m_fg) i_fetch_req = 1'b0;
  endtask

  // Issue one data request, wait for its grant, then run 'post' more cycles.
  task automatic data_access(input logic we, input logic [8:0] a, input logic [15:0] wd,
                             input int post);
    int n = 0;
    cs_cnt = 0; we_cnt = 0;
    i_dreq = 1'b1; i_dwe = we; i_daddr = a; i_dwdata = wd;
    do begin
      tick();
      n++;
    end while (!m_dg && (n < 20));
    if (!m_dg) begin
      chk("dgnt_timeout", 32'(m_dg), 32'd1);
      i_dreq = 1'b0;
    end
    repeat (post) tick();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      env_mem[i] = (i < 64) ? (16'hC000 + 16'(i)) : 16'h0000;
      ref_mem[i] = env_mem[i];
    end
    RESET = 1'b1; i_fetch_req = 1'b0; i_pc = 9'h0;
    i_dreq = 1'b0; i_dwe = 1'b0; i_daddr = 9'h0; i_dwdata = 16'h0;
    m_busy = 0; m_dg = 1'b0; m_fg = 1'b0;
    t_data = 1'b0; t_we = 1'b0; t_oor = 1'b0; t_addr = 9'h0; t_pc = 9'h0; t_wdata = 16'h0;
    cs_cnt = 0; we_cnt = 0; dv_cnt = 0;

    @(posedge CLK);
    env_step();
    model_step();
    @(negedge CLK);
    check_regs();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_cnt",  32'(o_fault_cnt), 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // store then load back from RAM
    data_access(1'b1, 9'h080, 16'h1234, 2);
    chk("st_dvalid", 32'(o_dvalid), 32'd1);
    chk("st_dfault", 32'(o_dfault), 32'd0);
    chk("st_we_cycles", 32'(we_cnt), 32'd1);
    data_access(1'b0, 9'h080, 16'h0000, 2);
    chk("ld_dvalid", 32'(o_dvalid), 32'd1);
    chk("ld_drdata", 32'(o_drdata), 32'h1234);
    chk("ld_dfault", 32'(o_dfault), 32'd0);

    // store into ROM faults; load from ROM does not
    data_access(1'b1, 9'h010, 16'h5555, 2);
    chk("rom_st_dfault", 32'(o_dfault), 32'd1);
    chk("rom_st_cnt", 32'(o_fault_cnt), 32'd1);
    data_access(1'b0, 9'h010, 16'h0000, 2);
    chk("rom_ld_drdata", 32'(o_drdata), 32'hC010);
    chk("rom_ld_dfault", 32'(o_dfault), 32'd0);

    // simultaneous fetch and data request: data first, fetch on the valid cycle
    i_fetch_req = 1'b1; i_pc = 9'h000;
    i_dreq = 1'b1; i_dwe = 1'b0; i_daddr = 9'h090;
    #1;
    chk("prio_dgnt", 32'(o_dgnt), 32'd1);
    chk("prio_fgnt", 32'(o_fetch_gnt), 32'd0);
    data_access(1'b0, 9'h090, 16'h0000, 2);
    chk("prio_dvalid", 32'(o_dvalid), 32'd1);
    #1;
    chk("fgnt_on_dvalid", 32'(o_fetch_gnt), 32'd1);
    tick();
    chk("fetch_cs", 32'(o_mem_cs), 32'd1);
    chk("fetch_sel", 32'(o_mem_sel), 32'd0);
    tick();
    tick();
    chk("fetch_ivalid", 32'(o_instr_valid), 32'd1);
    chk("fetch_instr", 32'(o_instr), 32'hC000);

    // out-of-range load: no memory strobe, same latency
    data_access(1'b0, 9'h100, 16'h0000, 2);
    chk("oor_cs_cycles", 32'(cs_cnt), 32'd0);
    chk("oor_dvalid", 32'(o_dvalid), 32'd1);
    chk("oor_dfault", 32'(o_dfault), 32'd1);

    // reset while a store is on the memory bus
    data_access(1'b1, 9'h090, 16'hBEEF, 0);
    chk("pre_rst_we", 32'(o_mem_we), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_busy2", 32'(o_busy), 32'd0);
    chk("rst_we2", 32'(o_mem_we), 32'd0);
    chk("rst_addr2", 32'(o_mem_addr), 32'd0);
    chk("rst_drdata2", 32'(o_drdata), 32'd0);
    chk("rst_instr2", 32'(o_instr), 32'd0);
    chk("rst_cnt2", 32'(o_fault_cnt), 32'd0);
    dv_cnt = 0;
    repeat (4) tick();
    chk("rst_no_dvalid", 32'(dv_cnt), 32'd0);

    // fault counter saturation
    for (int k = 0; k < 260; k++) begin
      data_access(1'b1, 9'h005, 16'($urandom), 2);
      if (k == 0) chk("sat_first", 32'(o_fault_cnt), 32'd1);
    end
    chk("sat_cnt", 32'(o_fault_cnt), 32'd255);

    RESET = 1'b1;
    tick();
    RESET = 1'b0;

    // randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      RESET = ($urandom_range(0, 99) == 0);
      if (!i_dreq) begin
        i_dwe    = 1'($urandom_range(0, 1));
        i_daddr  = 9'($urandom_range(0, 511));
        i_dwdata = 16'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          i_dreq = 1'b1;
          case ($urandom_range(0, 3))
            0:       i_daddr = 9'($urandom_range(0, 63));
            3:       i_daddr = 9'($urandom_range(256, 511));
            default: i_daddr = 9'($urandom_range(64, 255));
          endcase
        end
      end
      if (!i_fetch_req) begin
        i_pc = 9'($urandom_range(0, 255));
        if ($urandom_range(0, 2) == 0) i_fetch_req = 1'b1;
      end
      tick();
    end
    RESET = 1'b0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
